// File: rtl/vga_scan_gen_if.sv
// vga_scan_gen_if: colour-mapper query/answer pair and DAC-side outputs of
// the VGA scan generator. The master modport is the generator itself; the
// slave modport is its environment (SoC colour mapper plus DAC).
interface vga_scan_gen_if;
    logic [9:0] cm_x;
    logic [9:0] cm_y;
    logic [7:0] cm_r;
    logic [7:0] cm_g;
    logic [7:0] cm_b;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic       frame_start;

    modport master (
        output cm_x, cm_y,
        input  cm_r, cm_g, cm_b,
        output vga_r, vga_g, vga_b,
        output vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start
    );

    modport slave (
        input  cm_x, cm_y,
        output cm_r, cm_g, cm_b,
        input  vga_r, vga_g, vga_b,
        input  vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start
    );
endinterface

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480@60 pixel-timing generator and display back end.
// Counters drive the colour-mapper query (cm_x/cm_y); the mapper answer
// arrives CM_LATENCY cycles later and is registered once more, so every
// output (RGB, syncs, blank, frame_start) lags the counters by
// CM_LATENCY+1 cycles and all outputs stay mutually aligned.
// Optional feature: define VGA_TEST_PATTERN_EN to add the test_pattern
// input, which replaces the mapper colour with eight vertical colour bars.
module vga_scan_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned CM_LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic           test_pattern,
`endif
    vga_scan_gen_if.master vga
);

    localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(HT - 1);
    localparam logic [9:0] V_LAST  = 10'(VT - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]            r_hcnt;
    logic [9:0]            r_vcnt;
    logic                  w_act;
    logic                  w_hs_raw;
    logic                  w_vs_raw;
    logic                  w_fs_raw;
    logic                  w_act_d;
    logic [CM_LATENCY:0]   r_act_sr;
    logic [CM_LATENCY:0]   r_hs_sr;
    logic [CM_LATENCY:0]   r_vs_sr;
    logic [CM_LATENCY:0]   r_fs_sr;
    logic [23:0]           w_rgb_src;
    logic [23:0]           w_rgb_next;
    logic [23:0]           r_rgb;

    // Pixel and line counters; the line counter steps on pixel wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 10'd1;
        end
    end

    // Raw timing flags decoded from the current counter state.
    always_comb begin
        w_act    = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
        w_hs_raw = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
        w_vs_raw = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
        w_fs_raw = (r_hcnt == '0) && (r_vcnt == '0);
    end

    // Timing flags ride a CM_LATENCY+1 deep delay line; reset fills it with
    // inactive levels so no partial pulses leave after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_sr <= '0;
            r_hs_sr  <= '1;
            r_vs_sr  <= '1;
            r_fs_sr  <= '0;
        end else begin
            r_act_sr[0] <= w_act;
            r_hs_sr[0]  <= w_hs_raw;
            r_vs_sr[0]  <= w_vs_raw;
            r_fs_sr[0]  <= w_fs_raw;
            for (int unsigned i = 1; i <= CM_LATENCY; i++) begin
                r_act_sr[i] <= r_act_sr[i-1];
                r_hs_sr[i]  <= r_hs_sr[i-1];
                r_vs_sr[i]  <= r_vs_sr[i-1];
                r_fs_sr[i]  <= r_fs_sr[i-1];
            end
        end
    end

    // Active flag aligned with the cycle the mapper answer is sampled.
    if (CM_LATENCY == 0) begin : g_act_d0
        assign w_act_d = w_act;
    end else begin : g_act_dn
        assign w_act_d = r_act_sr[CM_LATENCY-1];
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    logic        r_tp;
    logic [9:0]  w_hcnt_d;
    logic [2:0]  w_bar;
    logic [23:0] w_bar_rgb;

    // Test-pattern select, registered once like the counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tp <= 1'b0;
        end else begin
            r_tp <= test_pattern;
        end
    end

    if (CM_LATENCY == 0) begin : g_hcnt_d0
        assign w_hcnt_d = r_hcnt;
    end else begin : g_hcnt_dn
        logic [9:0] r_hcnt_sr [CM_LATENCY];

        // Pixel column delayed to line up with the sampled mapper answer.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int unsigned i = 0; i < CM_LATENCY; i++) begin
                    r_hcnt_sr[i] <= '0;
                end
            end else begin
                r_hcnt_sr[0] <= r_hcnt;
                for (int unsigned i = 1; i < CM_LATENCY; i++) begin
                    r_hcnt_sr[i] <= r_hcnt_sr[i-1];
                end
            end
        end

        assign w_hcnt_d = r_hcnt_sr[CM_LATENCY-1];
    end

    // Bar colours: bit0 of the bar index drops blue, bit1 red, bit2 green,
    // giving white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        w_bar     = 3'(w_hcnt_d / BAR_W);
        w_bar_rgb = {{8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}};
    end
`endif

    // Colour source select and blanking.
    always_comb begin
        w_rgb_src = {vga.cm_r, vga.cm_g, vga.cm_b};
`ifdef VGA_TEST_PATTERN_EN
        if (r_tp) begin
            w_rgb_src = w_bar_rgb;
        end
`endif
        w_rgb_next = w_act_d ? w_rgb_src : '0;
    end

    // Output colour register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_rgb_next;
        end
    end

    assign vga.cm_x        = r_hcnt;
    assign vga.cm_y        = r_vcnt;
    assign vga.vga_r       = r_rgb[23:16];
    assign vga.vga_g       = r_rgb[15:8];
    assign vga.vga_b       = r_rgb[7:0];
    assign vga.vga_hs      = r_hs_sr[CM_LATENCY];
    assign vga.vga_vs      = r_vs_sr[CM_LATENCY];
    assign vga.vga_blank_n = r_act_sr[CM_LATENCY];
    assign vga.frame_start = r_fs_sr[CM_LATENCY];
    assign vga.vga_sync_n  = 1'b0;

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Pixel-timing generator and display back end for the 640x480@60 VGA path. Drives the colour-mapper query pair (`cm_x`, `cm_y`) into the SoC, takes back the SoC's 24-bit colour answer, and emits pipeline-aligned RGB, sync and blank to the DAC. It also returns the vertical sync to the SoC `vga_vs` input for frame pacing. It runs entirely on the 25 MHz pixel clock produced by the SoC PLL.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CM_LATENCY`, 2, cycles from `cm_x`/`cm_y` to valid `cm_r/g/b`; range 0..7
- `clk` in 1: 25 MHz pixel clock, the only clock
- `reset` in 1: asynchronous, active-high
- `cm_x` out 10: horizontal counter value sent to the colour mapper
- `cm_y` out 10: vertical counter value sent to the colour mapper
- `cm_r`, `cm_g`, `cm_b` in 8 each: colour-mapper answer
- `vga_r`, `vga_g`, `vga_b` out 8 each: DAC colour
- `vga_hs` out 1: horizontal sync, active low
- `vga_vs` out 1: vertical sync, active low; also routed to SoC `vga_vs`
- `vga_blank_n` out 1: low outside the active area
- `vga_sync_n` out 1: constant 0
- `frame_start` out 1: one-cycle pulse on the first visible pixel of each frame, at the output

## Operation
- The horizontal total is `HT` = sum of the H parameters (800). The vertical total is `VT` = sum of the V parameters (525).
- `hcnt` counts 0..HT-1 and wraps to 0. On wrap, `vcnt` increments, and wraps 0 after VT-1. The simultaneous wrap of both counters at (HT-1, VT-1) goes to (0, 0).
- `cm_x` = `hcnt` and `cm_y` = `vcnt`, driven straight from the counter registers. Both fit in 10 bits for the defaults. Out-of-area values (x ≥ 640 or y ≥ 480) are presented, and their answers are discarded.
- The raw active signal is `act` = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- The raw horizontal sync `hs_raw` is low for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC, which is 656..751.
- The raw vertical sync `vs_raw` is low for V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC, which is 490..491.
- `fs_raw` = (hcnt == 0 && vcnt == 0).
- `act`, `hs_raw`, `vs_raw` and `fs_raw` pass through a shift delay of CM_LATENCY+1 stages.
- The output RGB register loads `act_d ? cm_rgb : 0`. Here `act_d` is `act` delayed CM_LATENCY stages.
- There is no backpressure and no handshake. The colour mapper must honour CM_LATENCY exactly.

## Timing
- Counter values at cycle t appear on `cm_x`/`cm_y` at t. `cm_rgb` is sampled at t+CM_LATENCY and is visible on `vga_r/g/b` at t+CM_LATENCY+1.
- `vga_hs`, `vga_vs`, `vga_blank_n` and `frame_start` for counter state t are also visible at t+CM_LATENCY+1. All outputs are therefore mutually aligned.
- Reset values:
  - counters 0, so `cm_x` = `cm_y` = 0
  - `vga_r/g/b` = 0
  - `vga_hs` = 1, `vga_vs` = 1
  - `vga_blank_n` = 0, `frame_start` = 0
  - every delay stage holds the inactive value
- Reset deasserting mid-frame restarts at (0, 0). No partial pulses are generated, because the delay stages hold inactive values.
- `hcnt` advances on the first clock edge after `reset` deasserts. After that, the line period is 800 cycles and the frame period is 420 000 cycles.

## Configuration
- `VGA_TEST_PATTERN_EN` defined:
  - adds input `test_pattern` (1 bit), registered once, with its delay matched to `cm_x`
  - when the registered `test_pattern` is high, the RGB mux selects eight 80-pixel vertical bars from delayed `hcnt` instead of `cm_rgb`
  - bar order: white, yellow, cyan, green, magenta, red, blue, black (channels 0xFF/0x00)
  - blanking still forces 0
- Not defined: no `test_pattern` port. RGB is always sourced from `cm_rgb`.

## Test plan
- Reset for 5 cycles with CM_LATENCY=2, then release → outputs stay at reset values. The first `vga_hs` fall is 659 cycles after the first post-reset edge, and it stays low for 96 cycles.
- Run 2 frames → `vga_vs` low for exactly 1600 cycles per frame. `frame_start` pulses are exactly 420 000 cycles apart. Each pulse coincides with `vga_blank_n` rising.
- Model the mapper as `cm_r` = x[7:0] and `cm_g` = y[7:0], delayed 2 cycles → at the output pixel for (x=5, y=7), `vga_r` = 5 and `vga_g` = 7. Output pixel (x=639) is followed by `vga_r` = 0 with `vga_blank_n` = 0.
- Drive `cm_r/g/b` = 0xFF constantly → all 24 bits are 0 whenever `vga_blank_n` = 0. 640 × 480 = 307 200 non-zero pixels per frame.
- Assert `reset` at line 200, pixel 300 → all outputs take reset values immediately (asynchronously). After release, the next `frame_start` is 420 000 cycles after the first visible pixel.
- With `VGA_TEST_PATTERN_EN` and `test_pattern` = 1 → output x = 0..79 gives 0xFFFFFF, x = 80 gives 0xFFFF00, and x = 560..639 gives 0x000000, all independent of `cm_rgb`.
